// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and coin values for the vending controller
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_PAYOUT  = 2'd3
  } state_t;

  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] ONE  = 2'd2;

  // Value in half-units of the coins seen this cycle; both pulses together give 3.
  function automatic logic [1:0] coin_value(input logic half, input logic one);
    logic [1:0] v;
    v = 2'd0;
    if (half) v = v + HALF;
    if (one)  v = v + ONE;
    return v;
  endfunction

endpackage

// File: rtl/vend_if.sv
// rtl/vend_if.sv - coin/key inputs and dispenser/display outputs of the vending controller
interface vend_if #(
  parameter int CREDIT_W = 4
);

  logic                coin_half;
  logic                coin_one;
  logic                cancel;
  logic                po_cola;
  logic                po_change;
  logic                coin_rej;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic [3:0]          led;

  // Front-end side: raises coin and cancel pulses, watches the board outputs.
  modport master (
    output coin_half, coin_one, cancel,
    input  po_cola, po_change, coin_rej, credit, busy, led
  );

  // Controller side.
  modport slave (
    input  coin_half, coin_one, cancel,
    output po_cola, po_change, coin_rej, credit, busy, led
  );

endinterface

// File: rtl/vend_ctrl_blink_div.sv
// rtl/vend_ctrl_blink_div.sv - free-running divider that toggles the idle LED flag
module blink_div #(
  parameter int unsigned BLINK_CYC = 50000000
) (
  input  logic sclk,
  input  logic rst,
  output logic blink
);

  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYC - 1);

  logic [BW-1:0] cnt;

  // Count BLINK_CYC cycles, then flip the flag; only reset ever restarts the phase.
  always_ff @(posedge sclk) begin
    if (rst) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (cnt == B_LAST) begin
      cnt   <= '0;
      blink <= ~blink;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - parametrised vending FSM with credit, timeout refund and change payout
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int          PRICE       = 5,
  parameter int          CREDIT_W    = 4,
  parameter int unsigned TIMEOUT_CYC = 1500000000,
  parameter int unsigned BLINK_CYC   = 50000000,
  parameter int unsigned CHG_GAP     = 4
) (
  input logic sclk,
  input logic rst,
  vend_if.slave bus
);

  localparam int SW = CREDIT_W + 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (CHG_GAP > 1) ? $clog2(CHG_GAP) : 1;
  localparam logic [SW-1:0] PRICE_V  = SW'(PRICE);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] G_RELOAD = GW'(CHG_GAP - 1);

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_q, credit_nx;
  logic [CREDIT_W-1:0] rem_q, rem_nx;
  logic [TW-1:0]       timer_q, timer_nx;
  logic [GW-1:0]       gap_q, gap_nx;
  logic                coin_rej_q;
  logic                blink;
  logic                busy;
  logic [1:0]          add;
  logic [SW-1:0]       sum;

  assign add  = coin_value(bus.coin_half, bus.coin_one);
  // Widened by one bit so credit plus a double coin can never wrap before the price compare.
  assign sum  = {1'b0, credit_q} + SW'(add);
  assign busy = (state == S_VEND) || (state == S_PAYOUT);

  assign bus.busy      = busy;
  assign bus.po_cola   = (state == S_VEND);
  assign bus.po_change = (state == S_PAYOUT) && (gap_q == '0) && (rem_q != '0);
  assign bus.coin_rej  = coin_rej_q;
  assign bus.credit    = credit_q;
  assign bus.led       = busy ? 4'b1111 : {4{blink}};

  blink_div #(
    .BLINK_CYC (BLINK_CYC)
  ) u_blink (
    .sclk  (sclk),
    .rst   (rst),
    .blink (blink)
  );

  // State, credit, change and timer registers; reset drops any pending change.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state      <= S_IDLE;
      credit_q   <= '0;
      rem_q      <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
      coin_rej_q <= 1'b0;
    end else begin
      state      <= state_nx;
      credit_q   <= credit_nx;
      rem_q      <= rem_nx;
      timer_q    <= timer_nx;
      gap_q      <= gap_nx;
      coin_rej_q <= busy && (add != 2'd0);
    end
  end

  // Next-state logic: coins beat cancel, cancel beats timeout; payout spaces pulses by CHG_GAP.
  always_comb begin
    state_nx  = state;
    credit_nx = credit_q;
    rem_nx    = rem_q;
    timer_nx  = timer_q;
    gap_nx    = gap_q;
    case (state)
      S_IDLE: begin
        timer_nx = '0;
        if (add != 2'd0) begin
          credit_nx = CREDIT_W'(add);
          state_nx  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (sum >= PRICE_V) begin
          rem_nx    = CREDIT_W'(sum - PRICE_V);
          credit_nx = '0;
          timer_nx  = '0;
          state_nx  = S_VEND;
        end else if (add != 2'd0) begin
          credit_nx = sum[CREDIT_W-1:0];
          timer_nx  = '0;
        end else if (bus.cancel || (timer_q == T_LAST)) begin
          rem_nx    = credit_q;
          credit_nx = '0;
          timer_nx  = '0;
          gap_nx    = '0;
          state_nx  = S_PAYOUT;
        end else begin
          timer_nx = timer_q + 1'b1;
        end
      end
      S_VEND: begin
        gap_nx   = '0;
        state_nx = (rem_q == '0) ? S_IDLE : S_PAYOUT;
      end
      S_PAYOUT: begin
        if (rem_q == '0) begin
          state_nx = S_IDLE;
        end else if (gap_q == '0) begin
          rem_nx = rem_q - 1'b1;
          gap_nx = G_RELOAD;
          if (rem_q == CREDIT_W'(1)) state_nx = S_IDLE;
        end else begin
          gap_nx = gap_q - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed self-checking bench for vend_ctrl
module tb_vend_ctrl;

  logic sclk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc;
  int   cola_cnt;
  int   chg_cnt;
  int   prev_chg_cyc;
  int   last_chg_cyc;
  int   led_bad;
  int   base_cola;
  int   base_chg;

  vend_if #(.CREDIT_W(4)) bus ();

  vend_ctrl #(
    .PRICE       (5),
    .CREDIT_W    (4),
    .TIMEOUT_CYC (20),
    .BLINK_CYC   (8),
    .CHG_GAP     (3)
  ) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Cycle counter used to time pulse spacing.
  always @(posedge sclk) cyc <= cyc + 1;

  // Pulse counters and LED-while-busy watch, sampled mid-cycle.
  always @(negedge sclk) begin
    if (bus.po_cola) cola_cnt <= cola_cnt + 1;
    if (bus.po_change) begin
      chg_cnt      <= chg_cnt + 1;
      prev_chg_cyc <= last_chg_cyc;
      last_chg_cyc <= cyc;
    end
    if (bus.busy && bus.led !== 4'b1111) led_bad <= led_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic coin(input logic h, input logic o, input logic c);
    bus.coin_half = h;
    bus.coin_one  = o;
    bus.cancel    = c;
    step(1);
    bus.coin_half = 1'b0;
    bus.coin_one  = 1'b0;
    bus.cancel    = 1'b0;
  endtask

  task automatic mark();
    base_cola = cola_cnt;
    base_chg  = chg_cnt;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    cola_cnt = 0; chg_cnt = 0; prev_chg_cyc = 0; last_chg_cyc = 0; led_bad = 0;
    bus.coin_half = 1'b0; bus.coin_one = 1'b0; bus.cancel = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;

    check("rst_credit", 32'(bus.credit), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_cola", 32'(bus.po_cola), 0);
    check("rst_change", 32'(bus.po_change), 0);
    check("rst_rej", 32'(bus.coin_rej), 0);
    check("rst_led", 32'(bus.led), 0);

    // Idle blink: toggles every 8 cycles from reset.
    step(7);
    check("led_pre_toggle", 32'(bus.led), 0);
    step(1);
    check("led_toggle_on", 32'(bus.led), 32'hf);
    step(8);
    check("led_toggle_off", 32'(bus.led), 0);

    // Five halves: exact price, no change.
    mark();
    for (int i = 1; i <= 4; i++) begin
      coin(1'b1, 1'b0, 1'b0);
      check("half_credit", 32'(bus.credit), 32'(i));
      step(1);
    end
    coin(1'b1, 1'b0, 1'b0);
    check("half_cola", 32'(bus.po_cola), 1);
    check("half_busy_led", 32'(bus.led), 32'hf);
    step(1);
    check("half_idle_busy", 32'(bus.busy), 0);
    step(3);
    check("half_cola_cnt", 32'(cola_cnt - base_cola), 1);
    check("half_chg_cnt", 32'(chg_cnt - base_chg), 0);

    // Three ones: one half-unit of change.
    mark();
    coin(1'b0, 1'b1, 1'b0);
    coin(1'b0, 1'b1, 1'b0);
    check("one_credit4", 32'(bus.credit), 4);
    coin(1'b0, 1'b1, 1'b0);
    check("one_cola", 32'(bus.po_cola), 1);
    step(1);
    check("one_change_lat", 32'(bus.po_change), 1);
    step(1);
    check("one_idle_busy", 32'(bus.busy), 0);
    check("one_credit0", 32'(bus.credit), 0);
    step(3);
    check("one_chg_cnt", 32'(chg_cnt - base_chg), 1);
    check("one_cola_cnt", 32'(cola_cnt - base_cola), 1);

    // Credit 4 plus simultaneous half and one: two change pulses CHG_GAP apart.
    mark();
    coin(1'b0, 1'b1, 1'b0);
    coin(1'b0, 1'b1, 1'b0);
    coin(1'b1, 1'b1, 1'b0);
    check("dbl_cola", 32'(bus.po_cola), 1);
    step(8);
    check("dbl_chg_cnt", 32'(chg_cnt - base_chg), 2);
    check("dbl_gap", 32'(last_chg_cyc - prev_chg_cyc), 3);
    check("dbl_busy", 32'(bus.busy), 0);

    // Cancel after 1.5 yuan: full refund, no item.
    mark();
    coin(1'b0, 1'b1, 1'b0);
    coin(1'b1, 1'b0, 1'b0);
    check("cxl_credit3", 32'(bus.credit), 3);
    coin(1'b0, 1'b0, 1'b1);
    check("cxl_credit0", 32'(bus.credit), 0);
    check("cxl_change_first", 32'(bus.po_change), 1);
    step(10);
    check("cxl_chg_cnt", 32'(chg_cnt - base_chg), 3);
    check("cxl_cola_cnt", 32'(cola_cnt - base_cola), 0);
    check("cxl_busy", 32'(bus.busy), 0);

    // Timeout refund after 20 idle cycles in COLLECT.
    mark();
    coin(1'b0, 1'b1, 1'b0);
    step(19);
    check("to_not_yet", 32'(bus.busy), 0);
    step(1);
    check("to_refund_pulse", 32'(bus.po_change), 1);
    step(5);
    check("to_chg_cnt", 32'(chg_cnt - base_chg), 2);
    check("to_busy", 32'(bus.busy), 0);

    // Coin at idle cycle 19 restarts the timer.
    mark();
    coin(1'b0, 1'b1, 1'b0);
    step(18);
    coin(1'b1, 1'b0, 1'b0);
    step(19);
    check("to2_no_refund", 32'(chg_cnt - base_chg), 0);
    check("to2_credit", 32'(bus.credit), 3);
    check("to2_busy", 32'(bus.busy), 0);
    step(1);
    check("to2_refund_pulse", 32'(bus.po_change), 1);
    step(8);
    check("to2_chg_cnt", 32'(chg_cnt - base_chg), 3);

    // Coin rejected during payout, then reset mid-payout.
    mark();
    coin(1'b0, 1'b1, 1'b0);
    coin(1'b0, 1'b1, 1'b0);
    coin(1'b1, 1'b1, 1'b0);
    step(1);
    check("rej_first_chg", 32'(bus.po_change), 1);
    coin(1'b1, 1'b0, 1'b0);
    check("rej_pulse", 32'(bus.coin_rej), 1);
    check("rej_credit", 32'(bus.credit), 0);
    check("rej_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    step(1);
    check("mid_rst_change", 32'(bus.po_change), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_rej", 32'(bus.coin_rej), 0);
    check("mid_rst_led", 32'(bus.led), 0);
    check("mid_rst_credit", 32'(bus.credit), 0);
    rst = 1'b0;
    step(6);
    check("mid_rst_chg_cnt", 32'(chg_cnt - base_chg), 1);

    check("led_steady_busy", 32'(led_bad), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
